// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order imem requests, buffers {pc, inst} for decode, squashes stale responses on redirect
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d, occ_q, occ_d, drop_q, drop_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d, pq_head_q, pq_head_d, pq_tail_q, pq_tail_d;
  logic            run_q;
  logic [XLEN-1:0] pq_q [DEPTH];
  logic [XLEN-1:0] buf_pc_q [DEPTH];
  logic [31:0]     buf_inst_q [DEPTH];
  logic            req_fire, drop, push, pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both in-flight requests and buffered entries, so every response has a slot.
  assign imem_req_valid = run_q && !redirect_valid &&
                          (({1'b0, inflight_q} + {1'b0, occ_q}) < (CW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // A response landing in the redirect cycle belongs to the old path and is discarded too.
  assign drop           = imem_rsp_valid && (redirect_valid || drop_q != '0);
  assign push           = imem_rsp_valid && !drop;
  assign pop            = inst_valid && inst_ready && !redirect_valid;
  assign inst_valid     = occ_q != '0;
  assign inst           = inst_valid ? buf_inst_q[head_q] : '0;
  assign inst_pc        = inst_valid ? buf_pc_q[head_q] : '0;
  assign opcode         = inst[6:0];

  // Next-state for PC, credit counters and queue pointers; redirect overrides everything.
  always_comb begin
    fetch_pc_d = redirect_valid ? (redirect_pc & ~XLEN'(3)) :
                 req_fire       ? fetch_pc_q + XLEN'(4)     : fetch_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d     = redirect_valid ? inflight_q - CW'(imem_rsp_valid) :
                 drop_q - CW'(imem_rsp_valid && drop_q != '0);
    occ_d      = redirect_valid ? '0 : occ_q + CW'(push) - CW'(pop);
    head_d     = redirect_valid ? '0 : pop ? inc(head_q) : head_q;
    tail_d     = redirect_valid ? '0 : push ? inc(tail_q) : tail_q;
    pq_tail_d  = req_fire ? inc(pq_tail_q) : pq_tail_q;
    pq_head_d  = imem_rsp_valid ? inc(pq_head_q) : pq_head_q;
  end

  // Control state, cleared asynchronously; fetching starts on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      occ_q      <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      pq_head_q  <= '0;
      pq_tail_q  <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      pq_head_q  <= pq_head_d;
      pq_tail_q  <= pq_tail_d;
      run_q      <= 1'b1;
    end
  end

  // Storage: in-flight PC queue (popped by every response, dropped or not) and the decode buffer.
  always_ff @(posedge clk) begin
    if (req_fire) pq_q[pq_tail_q] <= fetch_pc_q;
    if (push) begin
      buf_pc_q[tail_q]   <= pq_q[pq_head_q];
      buf_inst_q[tail_q] <= imem_rsp_data;
    end
  end

  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> inflight_q != '0);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against an in-order 1-cycle imem responder
module tb_fetch_unit;
  logic        clk = 0, rst_n = 0;
  logic        imem_req_valid, imem_req_ready = 1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic        inst_valid, inst_ready = 1;
  logic [31:0] inst, inst_pc;
  logic [6:0]  opcode;
  logic        rsp_en = 1;
  logic [31:0] q[$];
  int          checks = 0, errors = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .opcode(opcode)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return {8'hC3, a[23:0] ^ 24'h000033};
  endfunction

  // Memory: answers each accepted request in order, one cycle later, while rsp_en is set.
  initial begin
    logic fire, took;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      fire = imem_req_valid && imem_req_ready;
      a    = imem_req_addr;
      took = imem_rsp_valid;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        q.delete();
        imem_rsp_valid = 0;
      end else begin
        if (took && q.size() > 0) void'(q.pop_front());
        if (fire) q.push_back(a);
        imem_rsp_valid = rsp_en && q.size() > 0;
        imem_rsp_data  = q.size() > 0 ? dat(q[0]) : 32'h0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_inst(input logic [31:0] pc);
    logic [31:0] d;
    logic got;
    d = dat(pc);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = inst_valid;
    end
    chk("inst_seen", {31'b0, got}, 32'd1);
    if (got) begin
      chk("inst_pc", inst_pc, pc);
      chk("inst", inst, d);
      chk("opcode", {25'b0, opcode}, {25'b0, d[6:0]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic hit;
    // reset state
    #3;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_addr", imem_req_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1 chk("rel_req_valid0", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    chk("rel_req_valid1", {31'b0, imem_req_valid}, 32'd1);
    chk("rel_addr", imem_req_addr, 32'd0);
    // sequential fetch
    for (int k = 0; k < 5; k++) expect_inst(32'(4 * k));
    // decode stall: buffer fills with 20,24 and requests stop
    tick();
    inst_ready = 0;
    repeat (6) @(negedge clk);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("stall_inst_pc", inst_pc, 32'd20);
    chk("stall_inst", inst, dat(32'd20));
    chk("stall_addr", imem_req_addr, 32'd28);
    tick();
    inst_ready = 1;
    expect_inst(32'd20);
    expect_inst(32'd24);
    expect_inst(32'd28);
    // two requests in flight, then redirect
    rsp_en = 0;
    repeat (6) @(negedge clk);
    chk("inflight2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("inflight2_inst_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    redirect_valid = 1;
    redirect_pc = 32'h100;
    @(negedge clk);
    chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rsp_en = 1;
    tick();
    redirect_valid = 0;
    @(negedge clk);
    chk("redir_addr", imem_req_addr, 32'h100);
    chk("redir_inst_valid", {31'b0, inst_valid}, 32'd0);
    expect_inst(32'h100);
    // redirect coinciding with a response and a pop
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk);
      #2;
      hit = inst_valid && imem_rsp_valid;
    end
    chk("coincide_found", {31'b0, hit}, 32'd1);
    redirect_valid = 1;
    redirect_pc = 32'h100;
    @(negedge clk);
    chk("coincide_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 0;
    @(negedge clk);
    chk("coincide_addr", imem_req_addr, 32'h100);
    chk("coincide_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("coincide_req_valid_next", {31'b0, imem_req_valid}, 32'd1);
    expect_inst(32'h100);
    expect_inst(32'h104);
    // imem back-pressure holds the address
    tick();
    redirect_valid = 1;
    redirect_pc = 32'h8;
    imem_req_ready = 0;
    tick();
    redirect_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_addr", imem_req_addr, 32'h8);
    end
    chk("hold_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("hold_inst_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    redirect_valid = 1;
    redirect_pc = 32'h203;
    tick();
    redirect_valid = 0;
    imem_req_ready = 1;
    @(negedge clk);
    chk("align_addr", imem_req_addr, 32'h200);
    expect_inst(32'h200);
    expect_inst(32'h204);
    // reset mid-operation with a full buffer
    tick();
    inst_ready = 0;
    repeat (6) @(negedge clk);
    chk("full_inst_valid", {31'b0, inst_valid}, 32'd1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("mid_rst_inst", inst, 32'd0);
    chk("mid_rst_inst_pc", inst_pc, 32'd0);
    chk("mid_rst_opcode", {25'b0, opcode}, 32'd0);
    chk("mid_rst_addr", imem_req_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    inst_ready = 1;
    @(negedge clk);
    chk("rerel_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rerel_addr", imem_req_addr, 32'd0);
    expect_inst(32'd0);
    expect_inst(32'd4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
